// File: rtl/fft2d_seq.sv
// Sequences one N-point streaming FFT core over the rows and then the columns of an
// N x N frame held in a single working RAM, then streams the result out row-major.
module fft2d_seq #(
  parameter int N       = 32,
  parameter int LOG2N   = 5,
  parameter int AW      = 10,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             fwd_inv,
  input  logic             in_valid,
  input  logic [31:0]      in_re,
  input  logic [31:0]      in_im,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AW-1:0]    ram_addr,
  output logic             ram_we,
  output logic [63:0]      ram_din,
  input  logic [63:0]      ram_dout,
  output logic             fft_start,
  output logic             fft_fwd_inv,
  output logic             fft_xn_valid,
  output logic [31:0]      fft_xn_re,
  output logic [31:0]      fft_xn_im,
  input  logic             fft_dv,
  input  logic [LOG2N-1:0] fft_xk_index,
  input  logic [31:0]      fft_xk_re,
  input  logic [31:0]      fft_xk_im,
  output logic             out_valid,
  output logic             out_last,
  output logic [AW-1:0]    out_index,
  output logic [31:0]      out_re,
  output logic [31:0]      out_im
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_IN     = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_UNLOAD = 3'd3;
  localparam logic [2:0] S_OUT    = 3'd4;

  localparam int            CW  = AW + 1;
  localparam int            WDW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] NN  = CW'(N * N);

  logic [2:0]       r_state;
  logic             r_pass;
  logic [LOG2N-1:0] r_line;
  logic [LOG2N-1:0] r_k;
  logic [LOG2N-1:0] r_beat;
  logic [CW-1:0]    r_cnt;
  logic [WDW-1:0]   r_wdog;
  logic             r_err;
  logic             r_dir;
  logic             r_done;
  logic             r_start;
  logic             r_xn_vld;
  logic             r_out_vld;
  logic [AW-1:0]    r_out_idx;

  logic w_in_wr;
  logic w_un_wr;

  // N is a power of two, so line*N+idx is a concatenation; the column pass swaps the halves.
  function automatic logic [AW-1:0] f_addr(input logic col, input logic [LOG2N-1:0] ln,
                                           input logic [LOG2N-1:0] idx);
    return col ? {idx, ln} : {ln, idx};
  endfunction

  assign w_in_wr = (r_state == S_IN) && in_valid;
  assign w_un_wr = (r_state == S_UNLOAD) && fft_dv;
  assign ram_we  = !reset && (w_in_wr || w_un_wr);

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    case (r_state)
      S_IN: begin
        ram_addr = r_cnt[AW-1:0];
        if (in_valid) ram_din = {in_re, in_im};
      end
      S_LOAD:   ram_addr = f_addr(r_pass, r_line, r_k);
      S_UNLOAD: if (fft_dv) begin
        ram_addr = f_addr(r_pass, r_line, fft_xk_index);
        ram_din  = {fft_xk_re, fft_xk_im};
      end
      S_OUT:    ram_addr = r_cnt[AW-1:0];
      default: ;
    endcase
  end

  assign in_ready     = (r_state == S_IN);
  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign err          = r_err;
  assign fft_start    = r_start;
  assign fft_fwd_inv  = r_dir;
  assign fft_xn_valid = r_xn_vld;
  assign fft_xn_re    = r_xn_vld ? ram_dout[63:32] : '0;
  assign fft_xn_im    = r_xn_vld ? ram_dout[31:0]  : '0;
  assign out_valid    = r_out_vld;
  assign out_index    = r_out_idx;
  assign out_last     = r_out_vld && (r_out_idx == AW'(N * N - 1));
  assign out_re       = r_out_vld ? ram_dout[63:32] : '0;
  assign out_im       = r_out_vld ? ram_dout[31:0]  : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pass    <= 1'b0;
      r_line    <= '0;
      r_k       <= '0;
      r_beat    <= '0;
      r_cnt     <= '0;
      r_wdog    <= '0;
      r_err     <= 1'b0;
      r_dir     <= 1'b0;
      r_done    <= 1'b0;
      r_start   <= 1'b0;
      r_xn_vld  <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_idx <= '0;
    end else begin
      r_done    <= 1'b0;
      r_out_vld <= 1'b0;
      // RAM read latency: the core sees each load beat one cycle after its address.
      r_xn_vld  <= (r_state == S_LOAD);
      r_start   <= (r_state == S_LOAD) && (r_k == '0);
      case (r_state)
        S_IDLE: if (go) begin
          r_err   <= 1'b0;
          r_dir   <= fwd_inv;
          r_pass  <= 1'b0;
          r_line  <= '0;
          r_cnt   <= '0;
          r_state <= S_IN;
        end
        S_IN: if (in_valid) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == NN - 1'b1) begin
            r_k     <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_k <= r_k + 1'b1;
          if (r_k == LOG2N'(N - 1)) begin
            r_beat  <= '0;
            r_wdog  <= '0;
            r_state <= S_UNLOAD;
          end
        end
        S_UNLOAD: if (fft_dv) begin
          r_wdog <= '0;
          r_beat <= r_beat + 1'b1;
          if (r_beat == LOG2N'(N - 1)) begin
            if (r_line != LOG2N'(N - 1)) begin
              r_line  <= r_line + 1'b1;
              r_state <= S_LOAD;
            end else if (!r_pass) begin
              r_pass  <= 1'b1;
              r_line  <= '0;
              r_state <= S_LOAD;
            end else begin
              r_cnt   <= '0;
              r_state <= S_OUT;
            end
          end
        end else begin
          r_wdog <= r_wdog + 1'b1;
          if (r_wdog == WDW'(TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_OUT: if (r_cnt == NN) begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end else begin
          r_out_vld <= 1'b1;
          r_out_idx <= r_cnt[AW-1:0];
          r_cnt     <= r_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft2d_seq.sv
// Bench for fft2d_seq: N=4 frames through a behavioural core (identity, bit-reversed order,
// add-one, line reversal, dropped beat) with a separable 2D reference model and scoreboard.
module tb_fft2d_seq;
  localparam int N = 4, LOG2N = 2, AW = 4, TO = 64, L = 8, NN = 16;
  localparam int M_ID = 0, M_BR = 1, M_ADD = 2, M_REV = 3, M_DROP = 4;
  localparam int TOTAL = NN + 2 * N * (N + L + N) + NN + 1;

  logic clk = 1'b0;
  logic reset, go, fwd_inv, in_valid;
  logic [31:0] in_re, in_im;
  logic in_ready, busy, done, err;
  logic [AW-1:0] ram_addr;
  logic ram_we;
  logic [63:0] ram_din, ram_dout;
  logic fft_start, fft_fwd_inv, fft_xn_valid;
  logic [31:0] fft_xn_re, fft_xn_im;
  logic fft_dv;
  logic [LOG2N-1:0] fft_xk_index;
  logic [31:0] fft_xk_re, fft_xk_im;
  logic out_valid, out_last;
  logic [AW-1:0] out_index;
  logic [31:0] out_re, out_im;

  fft2d_seq #(.N(N), .LOG2N(LOG2N), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .go(go), .fwd_inv(fwd_inv),
    .in_valid(in_valid), .in_re(in_re), .in_im(in_im), .in_ready(in_ready),
    .busy(busy), .done(done), .err(err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .fft_start(fft_start), .fft_fwd_inv(fft_fwd_inv), .fft_xn_valid(fft_xn_valid),
    .fft_xn_re(fft_xn_re), .fft_xn_im(fft_xn_im),
    .fft_dv(fft_dv), .fft_xk_index(fft_xk_index), .fft_xk_re(fft_xk_re), .fft_xk_im(fft_xk_im),
    .out_valid(out_valid), .out_last(out_last), .out_index(out_index),
    .out_re(out_re), .out_im(out_im)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Working RAM: one-cycle read latency.
  logic [63:0] mem [NN];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  int cur_mode = M_ID;
  bit core_clr = 1'b0, stray_dv = 1'b0;
  int last_dv_cyc = 0;
  logic [31:0] cl1 [N];
  logic [63:0] img [NN];
  logic [63:0] exp_o [NN];
  logic [63:0] cap [NN];
  int exp_next = 0, dones = 0, busy_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] adj(input int m, input logic [63:0] v);
    logic [31:0] a, b;
    a = v[63:32];
    b = v[31:0];
    if (m == M_ADD) begin a = a + 32'd1; b = b + 32'd1; end
    return {a, b};
  endfunction

  function automatic int src(input int m, input int j);
    return (m == M_REV) ? N - 1 - j : j;
  endfunction

  function automatic int bitrev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) if (v[i]) r = r | (1 << (LOG2N - 1 - i));
    return r;
  endfunction

  // Behavioural core: collects N xn beats, waits L cycles, emits xk in chosen order.
  initial begin : core
    logic [63:0] xn [N];
    logic [63:0] xk [N];
    int xc, wt, b, ph, t, cidx;
    bit drv;
    xc = 0; wt = 0; b = 0; ph = 0; t = 0; cidx = 0; drv = 1'b0;
    fft_dv = 1'b0; fft_xk_index = '0; fft_xk_re = '0; fft_xk_im = '0;
    forever begin
      @(negedge clk);
      if (core_clr) begin
        xc = 0; ph = 0; t = 0; drv = 1'b0;
      end else begin
        if (drv) begin
          chk("ram_we on dv", 64'(ram_we), 64'd1);
          chk("dv write addr", 64'(ram_addr),
              64'((t / N == 0) ? (t % N) * N + cidx : cidx * N + (t % N)));
          last_dv_cyc = cyc;
        end
        if (fft_xn_valid) begin
          chk("fft_start", 64'(fft_start), 64'(xc == 0));
          xn[xc] = {fft_xn_re, fft_xn_im};
          if (t == N + 1) cl1[xc] = fft_xn_re;
          xc++;
          if (xc == N) begin
            for (int j = 0; j < N; j++) xk[j] = adj(cur_mode, xn[src(cur_mode, j)]);
            xc = 0; ph = 1; wt = L - 1;
          end
        end
      end
      @(posedge clk); #1;
      drv = 1'b0;
      fft_dv = 1'b0;
      if (ph == 1) begin
        if (wt == 0) begin ph = 2; b = 0; end
        else wt--;
      end
      if (ph == 2) begin
        if (b == N) begin
          ph = 0; t++;
        end else begin
          cidx = (cur_mode == M_BR) ? bitrev(b) : b;
          if (!(cur_mode == M_DROP && t == N + 2 && b == 2)) begin
            drv = 1'b1;
            fft_dv = 1'b1;
            fft_xk_index = LOG2N'(cidx);
            {fft_xk_re, fft_xk_im} = xk[cidx];
          end
          b++;
        end
      end
      if (stray_dv) begin
        fft_dv = 1'b1; fft_xk_index = LOG2N'(1); fft_xk_re = 32'hdead; fft_xk_im = 32'hbeef;
      end
    end
  end

  // Scoreboard: output stream, out_last, done placement, busy length.
  initial begin : sb
    bit prev_last;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (go && !busy) begin exp_next = 0; dones = 0; busy_cyc = 0; end
      if (busy) busy_cyc++;
      if (reset) prev_last = 1'b0;
      else begin
        if (done) dones++;
        if (prev_last) chk("done after last", 64'(done), 64'd1);
        else if (done) chk("done without last", 64'(done), 64'd0);
        prev_last = out_last;
        if (out_valid) begin
          chk("out_index", 64'(out_index), 64'(exp_next));
          chk("out_data", {out_re, out_im}, exp_o[exp_next % NN]);
          chk("out_last", 64'(out_last), 64'(exp_next == NN - 1));
          cap[out_index] = {out_re, out_im};
          exp_next++;
        end
      end
    end
  end

  // Reference: apply the core's line function to every row, then to every column.
  task automatic set_frame(input int m, input int kind);
    logic [63:0] tmp [NN];
    cur_mode = m;
    for (int i = 0; i < NN; i++)
      img[i] = (kind == 0) ? {32'(i), 32'(100 + i)} : (kind == 1) ? 64'd0 : {32'(i), 32'(3 * i)};
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) tmp[r * N + c] = adj(m, img[r * N + src(m, c)]);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) exp_o[r * N + c] = adj(m, tmp[src(m, r) * N + c]);
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic start(input bit dir);
    core_clr = 1'b1; step; core_clr = 1'b0;
    fwd_inv = dir; go = 1'b1; step; go = 1'b0; fwd_inv = ~dir;
    chk("busy after go", 64'(busy), 64'd1);
    chk("err after go", 64'(err), 64'd0);
    chk("fwd latched", 64'(fft_fwd_inv), 64'(dir));
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; {in_re, in_im} = img[i]; step;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit stray);
    int k;
    bit seen;
    k = 0; seen = 1'b0;
    while (k < 1000) begin
      @(negedge clk);
      k++;
      if (done) break;
      if (stray && out_valid && !seen) begin
        seen = 1'b1;
        @(posedge clk); #1;
        go = 1'b1; in_valid = 1'b1; in_re = 32'hbad; in_im = 32'hbad; stray_dv = 1'b1;
        repeat (3) step;
        go = 1'b0; in_valid = 1'b0; stray_dv = 1'b0;
      end
    end
    chk("done within budget", 64'(k < 1000), 64'd1);
    repeat (3) step;
    chk("one done pulse", 64'(dones), 64'd1);
    chk("outputs seen", 64'(exp_next), 64'(NN));
    chk("err clear at end", 64'(err), 64'd0);
    chk("busy cycles", 64'(busy_cyc), 64'(TOTAL));
  endtask

  task automatic chk_rst;
    chk("reset strobes", 64'({in_ready, busy, done, err, ram_we, fft_start, fft_xn_valid,
                              out_valid, out_last, fft_fwd_inv}), 64'd0);
    chk("reset ram bus", {60'(ram_addr), 4'd0} | ram_din, 64'd0);
    chk("reset xn bus", {fft_xn_re, fft_xn_im}, 64'd0);
    chk("reset out bus", {out_re, out_im} | 64'(out_index), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    reset = 1'b1; go = 1'b0; fwd_inv = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
    step; step; reset = 1'b0;
    chk_rst;

    // Identity core, in order
    set_frame(M_ID, 0); start(1'b1); feed(NN); wait_done(1'b0);
    for (int j = 0; j < N; j++) chk("column line 1 reads", 64'(cl1[j]), 64'(1 + 4 * j));
    chk("id out[0]", cap[0], {32'd0, 32'd100});
    chk("id out[7]", cap[7], {32'd7, 32'd107});
    chk("id out[15]", cap[15], {32'd15, 32'd115});

    // Bit-reversed emission order
    set_frame(M_BR, 0); start(1'b0); feed(NN); wait_done(1'b0);
    chk("br out[9]", cap[9], {32'd9, 32'd109});

    // Add one per pass
    set_frame(M_ADD, 1); start(1'b1); feed(NN); wait_done(1'b0);
    chk("add out[0]", cap[0], {32'd2, 32'd2});
    chk("add out[13]", cap[13], {32'd2, 32'd2});

    // Line reversal: out[r][c] = in[N-1-r][N-1-c]
    set_frame(M_REV, 2); start(1'b1); feed(NN); wait_done(1'b0);
    chk("rev out[0]", cap[0], {32'd15, 32'd45});
    chk("rev out[6]", cap[6], {32'd9, 32'd27});

    // Watchdog: a dropped beat in column line 2
    set_frame(M_DROP, 0); start(1'b1); feed(NN);
    k = 0;
    while (k < 2000 && !err) begin @(negedge clk); k++; end
    chk("err raised", 64'(err), 64'd1);
    chk("watchdog gap", 64'(cyc - last_dv_cyc), 64'(TO + 1));
    chk("idle after timeout", 64'(busy), 64'd0);
    repeat (4) step;
    chk("err sticky", 64'(err), 64'd1);
    chk("no done on timeout", 64'(dones), 64'd0);
    chk("no output on timeout", 64'(exp_next), 64'd0);

    // Next go clears err and completes
    set_frame(M_ID, 0); start(1'b1); feed(NN); wait_done(1'b0);

    // Reset while a write is being presented
    start(1'b1); feed(5);
    in_valid = 1'b1; {in_re, in_im} = img[5]; reset = 1'b1; core_clr = 1'b1;
    @(negedge clk);
    chk("no write in reset cycle", 64'(ram_we), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; core_clr = 1'b0; in_valid = 1'b0;
    chk_rst;

    // Reset during the row pass
    start(1'b1); feed(NN); repeat (30) step;
    chk("in row pass", 64'(busy), 64'd1);
    reset = 1'b1; core_clr = 1'b1; step; reset = 1'b0; core_clr = 1'b0;
    chk_rst;

    // Normal run with stray go/in_valid/fft_dv during output
    set_frame(M_REV, 2); start(1'b0); feed(NN); wait_done(1'b1);
    chk("stray rev out[0]", cap[0], {32'd15, 32'd45});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
